// File: rtl/bmr_tdee_mul_pkg.sv
// bmr_tdee_mul_pkg: mode encodings and the operand/slice width check for the pipelined multiplier
package bmr_tdee_mul_pkg;
  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MULXSS = 2'd1;
  localparam logic [1:0] MODE_MULXSU = 2'd2;
  localparam logic [1:0] MODE_MULXUU = 2'd3;
  function automatic bit width_ok(input int w, input int p);
    return p > 0 && w % p == 0;
  endfunction
endpackage

// File: rtl/bmr_tdee_mul_slice.sv
// bmr_tdee_mul_slice: registered unsigned PART_W x PART_W product (clk, reset, en, a, b -> p)
module bmr_tdee_mul_slice #(
  parameter int PART_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PART_W-1:0]     a,
  input  logic [PART_W-1:0]     b,
  output logic [2*PART_W-1:0]   p
);
  always_ff @(posedge clk)
    if (reset) p <= '0;
    else if (en) p <= a * b;
endmodule

// File: rtl/bmr_tdee_qsys_mul_unit.sv
// bmr_tdee_qsys_mul_unit: 2-stage sliced multiplier, in_valid/in_ready/in_a/in_b/in_mode/in_tag -> out_valid/out_ready/out_result/out_tag
module bmr_tdee_qsys_mul_unit
  import bmr_tdee_mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PART_W = 16,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N = WIDTH / PART_W;
  logic                  adv;
  logic                  s1_v;
  logic                  s1_sa;
  logic                  s1_sb;
  logic [1:0]            s1_mode;
  logic [TAG_W-1:0]      s1_tag;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic [2*PART_W-1:0]   pp [N*N];
  logic [2*WIDTH-1:0]    p;
  logic [WIDTH-1:0]      ph;
  logic [WIDTH-1:0]      ca;
  logic [WIDTH-1:0]      cb;
  logic [WIDTH-1:0]      res;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  if (!width_ok(WIDTH, PART_W)) begin : g_bad
    $fatal(1, "WIDTH must be a multiple of PART_W");
  end
  for (genvar i = 0; i < N; i++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      bmr_tdee_mul_slice #(.PART_W(PART_W)) u_slice (
        .clk  (clk),
        .reset(reset),
        .en   (adv),
        .a    (in_a[i*PART_W +: PART_W]),
        .b    (in_b[j*PART_W +: PART_W]),
        .p    (pp[i*N+j])
      );
    end
  end
  always_comb begin
    p = '0;
    for (int k = 0; k < N*N; k++) p = p + ((2*WIDTH)'(pp[k]) << (((k / N) + (k % N)) * PART_W));
    ph = p[2*WIDTH-1:WIDTH];
    ca = s1_sa ? s1_b : '0;
    cb = s1_sb ? s1_a : '0;
    res = s1_mode == MODE_MUL    ? p[WIDTH-1:0] :
          s1_mode == MODE_MULXSS ? ph - ca - cb :
          s1_mode == MODE_MULXSU ? ph - ca : ph;
  end
  always_ff @(posedge clk)
    if (reset) begin
      s1_v       <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv) begin
      s1_v       <= in_valid;
      s1_mode    <= in_mode;
      s1_tag     <= in_tag;
      s1_a       <= in_a;
      s1_b       <= in_b;
      s1_sa      <= in_a[WIDTH-1];
      s1_sb      <= in_b[WIDTH-1];
      out_valid  <= s1_v;
      out_result <= res;
      out_tag    <= s1_tag;
    end
endmodule
